// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard decoder slice:
// protocol bytes, set-2 modifier/lock scan codes and the LED FSM state enum.
package ps2_kbd_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_ED = 8'hED;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  // Bytes of the Pause sequence that follow the leading E1
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_ACK_CMD,
    SEND_ARG,
    WAIT_ACK_ARG
  } led_state_e;

  // Lock bit position in {caps, num, scroll}, zero for non-lock codes
  function automatic logic [2:0] lock_bit(input logic [7:0] code);
    case (code)
      SC_CAPS:   lock_bit = 3'b100;
      SC_NUM:    lock_bit = 3'b010;
      SC_SCROLL: lock_bit = 3'b001;
      default:   lock_bit = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// Bundle between the decoder and its surroundings: PHY rx/tx side plus key event outputs.
interface ps2_kbd_decoder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       phy_busy;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [2:0] mods;
  logic [2:0] locks;
  logic       led_busy;
  logic       err_pulse;

  modport master (
    output rx_valid, rx_data, phy_busy,
    input  tx_write, tx_data, key_valid, key_code, key_ext, key_break,
           mods, locks, led_busy, err_pulse
  );

  modport slave (
    input  rx_valid, rx_data, phy_busy,
    output tx_write, tx_data, key_valid, key_code, key_ext, key_break,
           mods, locks, led_busy, err_pulse
  );
endinterface

// File: rtl/ps2_led_ctrl.sv
// LED update sequencer: sends ED then the lock byte, waits for FA/FE with
// bounded retries and a reply timeout.
module ps2_led_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int RETRY_MAX   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_pending,
  input  logic [2:0] locks,
  input  logic       phy_busy,
  input  logic       ack,
  input  logic       nak,
  output logic       tx_write,
  output logic [7:0] tx_data,
  output logic       err_pulse,
  output logic       ack_window,
  output logic       pend_clr,
  output logic       active
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);

  led_state_e    state, state_n;
  logic [TW-1:0] timer;
  logic [RW-1:0] retries;
  logic          load_cmd, load_arg, retry_clr, retry_inc, fail, expired;

  assign expired = (timer == TW'(ACK_TIMEOUT - 1));
  assign active  = (state != IDLE);

  // A reply seen on the expiry cycle is checked before the timeout, so it wins
  always_comb begin
    state_n    = state;
    tx_write   = 1'b0;
    ack_window = 1'b0;
    pend_clr   = 1'b0;
    load_cmd   = 1'b0;
    load_arg   = 1'b0;
    retry_clr  = 1'b0;
    retry_inc  = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        if (led_pending && !phy_busy) begin
          state_n   = SEND_CMD;
          pend_clr  = 1'b1;
          load_cmd  = 1'b1;
          retry_clr = 1'b1;
        end
      end
      SEND_CMD, SEND_ARG: begin
        tx_write = 1'b1;
        if (phy_busy)
          state_n = (state == SEND_CMD) ? WAIT_ACK_CMD : WAIT_ACK_ARG;
      end
      WAIT_ACK_CMD, WAIT_ACK_ARG: begin
        ack_window = 1'b1;
        if (ack) begin
          if (state == WAIT_ACK_CMD) begin
            state_n   = SEND_ARG;
            load_arg  = 1'b1;
            retry_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (nak) begin
          if (retries < RW'(RETRY_MAX)) begin
            retry_inc = 1'b1;
            state_n   = (state == WAIT_ACK_CMD) ? SEND_CMD : SEND_ARG;
          end else begin
            fail    = 1'b1;
            state_n = IDLE;
          end
        end else if (expired) begin
          fail    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      retries   <= '0;
      tx_data   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      err_pulse <= fail;
      timer     <= ack_window ? timer + TW'(1) : '0;
      if (retry_clr)
        retries <= '0;
      else if (retry_inc)
        retries <= retries + RW'(1);
      if (load_cmd)
        tx_data <= BYTE_ED;
      else if (load_arg)
        tx_data <= {5'b00000, locks};
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Set-2 scan-code decoder: folds E0/F0/E1 prefixes into single key events,
// tracks modifier and lock state and requests LED updates on lock toggles.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int RETRY_MAX   = 2
) (
  input logic clk,
  input logic rst,
  ps2_kbd_decoder_if.slave bus
);

  logic       ext_flag, brk_flag;
  logic [2:0] skip_cnt;
  logic       key_valid_q, key_ext_q, key_break_q;
  logic [7:0] key_code_q;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic [2:0] locks_q, held;
  logic       led_pending;
  logic       is_reply, is_pause, is_key;
  logic [2:0] lock_hit, lock_toggle;
  logic       ack_window, pend_clr, active, tx_write, err_pulse;
  logic [7:0] tx_data;

  assign is_reply = (bus.rx_data == BYTE_FA) || (bus.rx_data == BYTE_FE);
  assign is_pause = (bus.rx_data == BYTE_E1);

  // Reply bytes and bytes swallowed by the Pause skip never reach the key path
  always_comb begin
    is_key      = bus.rx_valid && !is_reply && (skip_cnt == 3'd0) &&
                  !(bus.rx_data inside {BYTE_E0, BYTE_F0, BYTE_E1, BYTE_AA, 8'h00, 8'hFF});
    lock_hit    = (is_key && !ext_flag) ? lock_bit(bus.rx_data) : 3'b000;
    lock_toggle = brk_flag ? 3'b000 : (lock_hit & ~held);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      skip_cnt    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      {lshift, rshift, lctrl, rctrl, lalt, ralt} <= '0;
      locks_q     <= '0;
      held        <= '0;
      led_pending <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (bus.rx_valid && !is_reply) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else begin
          case (bus.rx_data)
            BYTE_E0: ext_flag <= 1'b1;
            BYTE_F0: brk_flag <= 1'b1;
            BYTE_AA, 8'h00, 8'hFF: begin
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
            default: begin
              key_valid_q <= 1'b1;
              key_code_q  <= bus.rx_data;
              key_ext_q   <= is_pause ? 1'b0 : ext_flag;
              key_break_q <= is_pause ? 1'b0 : brk_flag;
              ext_flag    <= 1'b0;
              brk_flag    <= 1'b0;
              if (is_pause)
                skip_cnt <= PAUSE_SKIP;
            end
          endcase
        end
      end

      if (is_key) begin
        case ({ext_flag, bus.rx_data})
          {1'b0, SC_LSHIFT}: lshift <= !brk_flag;
          {1'b0, SC_RSHIFT}: rshift <= !brk_flag;
          {1'b0, SC_CTRL}:   lctrl  <= !brk_flag;
          {1'b1, SC_CTRL}:   rctrl  <= !brk_flag;
          {1'b0, SC_ALT}:    lalt   <= !brk_flag;
          {1'b1, SC_ALT}:    ralt   <= !brk_flag;
          default: ;
        endcase
      end

      // Held bits gate typematic repeats so a lock flips once per press
      if (|lock_hit)
        held <= brk_flag ? (held & ~lock_hit) : (held | lock_hit);
      locks_q     <= locks_q ^ lock_toggle;
      led_pending <= (|lock_toggle) || (led_pending && !pend_clr);
    end
  end

  ps2_led_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .RETRY_MAX  (RETRY_MAX)
  ) u_led_ctrl (
    .clk        (clk),
    .rst        (rst),
    .led_pending(led_pending),
    .locks      (locks_q),
    .phy_busy   (bus.phy_busy),
    .ack        (bus.rx_valid && ack_window && (bus.rx_data == BYTE_FA)),
    .nak        (bus.rx_valid && ack_window && (bus.rx_data == BYTE_FE)),
    .tx_write   (tx_write),
    .tx_data    (tx_data),
    .err_pulse  (err_pulse),
    .ack_window (ack_window),
    .pend_clr   (pend_clr),
    .active     (active)
  );

  assign bus.tx_write  = tx_write;
  assign bus.tx_data   = tx_data;
  assign bus.err_pulse = err_pulse;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_break = key_break_q;
  assign bus.mods      = {lalt | ralt, lctrl | rctrl, lshift | rshift};
  assign bus.locks     = locks_q;
  assign bus.led_busy  = active | led_pending;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: a pressed-key-set model predicts key
// events, and directed PHY handshakes exercise the LED update sequencer.
module tb_ps2_kbd_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [2:0] mods;
    logic [2:0] locks;
  } ev_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ps2_kbd_decoder_if bus ();

  ps2_kbd_decoder #(
    .ACK_TIMEOUT(100),
    .RETRY_MAX  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the set of currently pressed keys, indexed ext*256+code
  bit         pressed [0:511];
  bit         m_ext, m_brk;
  int         m_skip;
  logic [2:0] m_locks;
  ev_t        exp_q[$];

  function automatic logic [2:0] model_mods();
    return {pressed[9'h011] | pressed[9'h111],
            pressed[9'h014] | pressed[9'h114],
            pressed[9'h012] | pressed[9'h059]};
  endfunction

  task automatic model_reset();
    foreach (pressed[i]) pressed[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_locks = 3'b000;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int key;
    if (b == 8'hFA || b == 8'hFE) return;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    case (b)
      8'hE0: m_ext = 1;
      8'hF0: m_brk = 1;
      8'hAA, 8'h00, 8'hFF: begin m_ext = 0; m_brk = 0; end
      8'hE1: begin
        exp_q.push_back('{code: 8'hE1, ext: 1'b0, brk: 1'b0, mods: model_mods(), locks: m_locks});
        m_ext = 0; m_brk = 0; m_skip = 7;
      end
      default: begin
        key = (m_ext ? 256 : 0) + int'(b);
        if (!m_brk && !pressed[key]) begin
          if (key == 'h058) m_locks ^= 3'b100;
          if (key == 'h077) m_locks ^= 3'b010;
          if (key == 'h07E) m_locks ^= 3'b001;
        end
        pressed[key] = !m_brk;
        exp_q.push_back('{code: b, ext: m_ext, brk: m_brk, mods: model_mods(), locks: m_locks});
        m_ext = 0; m_brk = 0;
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one byte for exactly one cycle; call at posedge+1
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic phy_accept(input logic [7:0] exp_byte, input string tag);
    int n = 0;
    while (!bus.tx_write && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_tx_write"}, 32'(bus.tx_write), 32'd1);
    checkOutput({tag, "_tx_data"}, 32'(bus.tx_data), 32'(exp_byte));
    bus.phy_busy = 1'b1;
    @(posedge clk); #1;
    bus.phy_busy = 1'b0;
    checkOutput({tag, "_tx_drop"}, 32'(bus.tx_write), 32'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    #1;
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
    checkOutput({tag, "_key"}, 32'({bus.key_code, bus.key_ext, bus.key_break}), 32'd0);
    checkOutput({tag, "_mods"}, 32'(bus.mods), 32'd0);
    checkOutput({tag, "_locks"}, 32'(bus.locks), 32'd0);
    checkOutput({tag, "_led_busy"}, 32'(bus.led_busy), 32'd0);
    checkOutput({tag, "_tx"}, 32'({bus.tx_write, bus.tx_data}), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err_pulse), 32'd0);
  endtask

  // Monitor: every key_valid pops one prediction
  ev_t got, want;
  always @(negedge clk) begin
    if (!rst && bus.key_valid) begin
      checks++;
      got = '{code: bus.key_code, ext: bus.key_ext, brk: bus.key_break,
              mods: bus.mods, locks: bus.locks};
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_key actual=%h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          begin
            errors++;
            $display("[TB] FAIL key_event actual code=%h ext=%b brk=%b mods=%b locks=%b expected code=%h ext=%b brk=%b mods=%b locks=%b",
                     got.code, got.ext, got.brk, got.mods, got.locks,
                     want.code, want.ext, want.brk, want.mods, want.locks);
          end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [7:0] pool [0:21];
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h77, 8'h7E,
             8'h29, 8'h5A, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'hFF,
             8'hE1, 8'h66};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.phy_busy = 1'b0;
    do_reset();
    check_all_zero("reset");

    $display("[TB] plain keys, prefixes and modifiers");
    applyStimulus(8'h1C);
    checkOutput("latency_1c", 32'(bus.key_valid), 32'd1);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'hE0); applyStimulus(8'hFA); applyStimulus(8'h1C);
    applyStimulus(8'hE0); applyStimulus(8'h14);
    applyStimulus(8'h12);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h14);
    drain("t12_drain");
    checkOutput("t2_mods", 32'(bus.mods), 32'b001);

    $display("[TB] lock toggle and LED update");
    applyStimulus(8'h58); applyStimulus(8'h58);
    applyStimulus(8'hF0); applyStimulus(8'h58);
    checkOutput("t3_locks", 32'(bus.locks), 32'b100);
    phy_accept(8'hED, "t3_cmd");
    applyStimulus(8'hFA);
    phy_accept(8'h04, "t3_arg");
    applyStimulus(8'hFA);
    checkOutput("t3_led_busy", 32'(bus.led_busy), 32'd0);

    $display("[TB] FE retries");
    bus.phy_busy = 1'b1;
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    bus.phy_busy = 1'b0;
    phy_accept(8'hED, "t4_cmd");
    applyStimulus(8'hFE);
    phy_accept(8'hED, "t4_retry1");
    applyStimulus(8'hFE);
    phy_accept(8'hED, "t4_retry2");
    applyStimulus(8'hFE);
    checkOutput("t4_err", 32'(bus.err_pulse), 32'd1);
    checkOutput("t4_led_busy", 32'(bus.led_busy), 32'd0);
    checkOutput("t4_locks", 32'(bus.locks), 32'b100);
    @(posedge clk); #1;
    checkOutput("t4_err_pulse_len", 32'(bus.err_pulse), 32'd0);
    checkOutput("t4_no_resend", 32'(bus.tx_write), 32'd0);

    $display("[TB] reply timeout");
    bus.phy_busy = 1'b1;
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    bus.phy_busy = 1'b0;
    phy_accept(8'hED, "t5_cmd");
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.err_pulse) begin
        k = i;
        break;
      end
    end
    checkOutput("t5_timeout_cycles", 32'(k), 32'd100);

    bus.phy_busy = 1'b1;
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    bus.phy_busy = 1'b0;
    phy_accept(8'hED, "t5b_cmd");
    repeat (99) @(posedge clk);
    #1;
    applyStimulus(8'hFA);
    checkOutput("t5b_reply_wins_err", 32'(bus.err_pulse), 32'd0);
    phy_accept({5'b00000, m_locks}, "t5b_arg");
    applyStimulus(8'hFA);
    checkOutput("t5b_led_busy", 32'(bus.led_busy), 32'd0);

    $display("[TB] pause sequence and reset mid-transfer");
    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
    applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
    drain("t6_pause_drain");
    checkOutput("t6_locks", 32'(bus.locks), 32'(m_locks));
    bus.phy_busy = 1'b1;
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    bus.phy_busy = 1'b0;
    phy_accept(8'hED, "t6_cmd");
    applyStimulus(8'hFA);
    phy_accept({5'b00000, m_locks}, "t6_arg");
    drain("t6_drain");
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("t6_rst");
    rst = 1'b0;
    model_reset();
    applyStimulus(8'hFA);
    checkOutput("t6_late_reply_busy", 32'(bus.led_busy), 32'd0);
    checkOutput("t6_late_reply_tx", 32'(bus.tx_write), 32'd0);

    $display("[TB] random scan-code stream");
    do_reset();
    bus.phy_busy = 1'b1;
    for (int i = 0; i < 400; i++)
      applyStimulus(pool[$urandom_range(0, 21)]);
    drain("rand_drain");
    checkOutput("rand_locks", 32'(bus.locks), 32'(m_locks));
    checkOutput("rand_mods", 32'(bus.mods), 32'(model_mods()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
